// File: rtl/aes_pkg.sv
// aes_pkg: shared widths and enums for the
// S-box lane scheduler.
package aes_pkg;

  localparam int AES_WORD_W  = 32;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_NB      = 4;

  typedef enum logic [1:0] {
    IDLE,
    KEY,
    ST
  } state_e;

  typedef enum logic {
    GNT_KEY,
    GNT_ST
  } gnt_e;

endpackage

// File: rtl/aes_sbox_arb2.sv
// aes_sbox_arb2: combinational two-way grant
// between key and state requesters.
module aes_sbox_arb2
  import aes_pkg::*;
#(
  parameter int KEY_PRIO = 0
) (
  input  logic i_key_v,
  input  logic i_st_v,
  input  gnt_e i_last,
  output logic o_gnt_key,
  output logic o_gnt_st
);

  // tie goes to key under priority, else to
  // whoever was not granted last time
  always_comb begin
    o_gnt_key = 1'b0;
    o_gnt_st  = 1'b0;
    unique case (1'b1)
      (i_key_v && !i_st_v): o_gnt_key = 1'b1;
      (!i_key_v && i_st_v): o_gnt_st  = 1'b1;
      (i_key_v && i_st_v): begin
        if (KEY_PRIO != 0 || i_last == GNT_ST)
          o_gnt_key = 1'b1;
        else
          o_gnt_st = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/aes_sbox_sched.sv
// aes_sbox_sched: time-shares one 32-bit S-box
// lane between key SubWord and state SubBytes.
module aes_sbox_sched
  import aes_pkg::*;
#(
  parameter int KEY_PRIO = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   key_req_valid,
  output logic                   key_req_ready,
  input  logic [AES_WORD_W-1:0]  key_req_word,
  output logic                   key_rsp_valid,
  output logic [AES_WORD_W-1:0]  key_rsp_word,
  input  logic                   st_req_valid,
  output logic                   st_req_ready,
  input  logic [AES_BLOCK_W-1:0] st_req_data,
  output logic                   st_rsp_valid,
  output logic [AES_BLOCK_W-1:0] st_rsp_data,
  output logic [AES_WORD_W-1:0]  sbox_in,
  input  logic [AES_WORD_W-1:0]  sbox_out,
  output logic                   busy
);

  localparam int LoW = (AES_NB - 1) * AES_WORD_W;

  state_e                 r_state;
  state_e                 w_nxt;
  logic [1:0]             r_wcnt;
  gnt_e                   r_last;
  logic [AES_WORD_W-1:0]  r_key_word;
  logic [AES_BLOCK_W-1:0] r_st_data;
  logic [AES_WORD_W-1:0]  r_key_rsp_word;
  logic                   r_key_rsp_valid;
  logic [AES_BLOCK_W-1:0] r_st_rsp_data;
  logic                   r_st_rsp_valid;

  logic                   w_gnt_key;
  logic                   w_gnt_st;
  logic                   w_key_rdy;
  logic                   w_st_rdy;
  logic                   w_key_fire;
  logic                   w_st_fire;
  logic [AES_WORD_W-1:0]  w_sbox_in;
  logic [6:0]             w_widx;

  aes_sbox_arb2 #(
    .KEY_PRIO (KEY_PRIO)
  ) u_arb (
    .i_key_v   (key_req_valid),
    .i_st_v    (st_req_valid),
    .i_last    (r_last),
    .o_gnt_key (w_gnt_key),
    .o_gnt_st  (w_gnt_st)
  );

  assign w_widx     = {r_wcnt, 5'd0};
  assign w_key_fire = w_key_rdy & key_req_valid;
  assign w_st_fire  = w_st_rdy & st_req_valid;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  // next state, ready and lane input
  always_comb begin
    w_nxt     = r_state;
    w_key_rdy = 1'b0;
    w_st_rdy  = 1'b0;
    w_sbox_in = '0;
    unique case (r_state)
      IDLE: begin
        w_key_rdy = w_gnt_key & rst_n;
        w_st_rdy  = w_gnt_st & rst_n;
        if (w_key_fire)     w_nxt = KEY;
        else if (w_st_fire) w_nxt = ST;
      end
      KEY: begin
        w_sbox_in = r_key_word;
        w_nxt     = IDLE;
      end
      ST: begin
        w_sbox_in = r_st_data[w_widx +: AES_WORD_W];
        if (r_wcnt == 2'd3) w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  // capture requests, collect lane results,
  // emit one-cycle response pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wcnt          <= 2'd0;
      r_last          <= GNT_ST;
      r_key_word      <= '0;
      r_st_data       <= '0;
      r_key_rsp_word  <= '0;
      r_key_rsp_valid <= 1'b0;
      r_st_rsp_data   <= '0;
      r_st_rsp_valid  <= 1'b0;
    end else begin
      r_key_rsp_valid <= 1'b0;
      r_st_rsp_valid  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_key_fire) begin
            r_key_word <= key_req_word;
            r_last     <= GNT_KEY;
          end else if (w_st_fire) begin
            r_st_data <= st_req_data;
            r_wcnt    <= 2'd0;
            r_last    <= GNT_ST;
          end
        end
        KEY: begin
          r_key_rsp_word  <= sbox_out;
          r_key_rsp_valid <= 1'b1;
        end
        ST: begin
          r_st_data[w_widx +: AES_WORD_W] <= sbox_out;
          r_wcnt <= r_wcnt + 2'd1;
          if (r_wcnt == 2'd3) begin
            r_st_rsp_valid <= 1'b1;
            r_st_rsp_data  <=
              {sbox_out, r_st_data[LoW-1:0]};
          end
        end
        default: ;
      endcase
    end
  end

  assign key_req_ready = w_key_rdy;
  assign st_req_ready  = w_st_rdy;
  assign key_rsp_valid = r_key_rsp_valid;
  assign key_rsp_word  = r_key_rsp_word;
  assign st_rsp_valid  = r_st_rsp_valid;
  assign st_rsp_data   = r_st_rsp_data;
  assign sbox_in       = w_sbox_in;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_aes_sbox_sched.sv
// tb_aes_sbox_sched: random and directed bench
// with a transaction-level reference model.
module tb_aes_sbox_sched;

  localparam int KP0 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, key_v, st_v;
  logic [31:0]  key_w;
  logic [127:0] st_d;
  logic         key_rdy, key_rv, st_rdy, st_rv, busy;
  logic [31:0]  key_rw, sin, sout;
  logic [127:0] st_rd;

  logic         rst1_n, k1_v, s1_v;
  logic [31:0]  k1_w;
  logic [127:0] s1_d;
  logic         k1_rdy, k1_rv, s1_rdy, s1_rv, busy1;
  logic [31:0]  k1_rw, sin1, sout1;
  logic [127:0] s1_rd;

  function automatic logic [7:0] gmul(
    input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // AES S-box: inverse in GF(2^8) as x^254,
  // then the affine transform
  function automatic logic [7:0] sb(
    input logic [7:0] x);
    logic [7:0] r, q;
    r = 8'h01;
    q = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, q);
      q = gmul(q, q);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
             ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(
    input logic [31:0] x);
    logic [31:0] w;
    for (int b = 0; b < 4; b++)
      w[8*b +: 8] = sb(x[8*b +: 8]);
    return w;
  endfunction

  function automatic logic [127:0] subblock(
    input logic [127:0] x);
    logic [127:0] w;
    for (int i = 0; i < 4; i++)
      w[32*i +: 32] = subword(x[32*i +: 32]);
    return w;
  endfunction

  assign sout  = subword(sin);
  assign sout1 = subword(sin1);

  aes_sbox_sched #(.KEY_PRIO(0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_req_valid (key_v),
    .key_req_ready (key_rdy),
    .key_req_word  (key_w),
    .key_rsp_valid (key_rv),
    .key_rsp_word  (key_rw),
    .st_req_valid  (st_v),
    .st_req_ready  (st_rdy),
    .st_req_data   (st_d),
    .st_rsp_valid  (st_rv),
    .st_rsp_data   (st_rd),
    .sbox_in       (sin),
    .sbox_out      (sout),
    .busy          (busy)
  );

  aes_sbox_sched #(.KEY_PRIO(1)) dut1 (
    .clk           (clk),
    .rst_n         (rst1_n),
    .key_req_valid (k1_v),
    .key_req_ready (k1_rdy),
    .key_req_word  (k1_w),
    .key_rsp_valid (k1_rv),
    .key_rsp_word  (k1_rw),
    .st_req_valid  (s1_v),
    .st_req_ready  (s1_rdy),
    .st_req_data   (s1_d),
    .st_rsp_valid  (s1_rv),
    .st_rsp_data   (s1_rd),
    .sbox_in       (sin1),
    .sbox_out      (sout1),
    .busy          (busy1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h @%0t",
               nm, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // model: one job in flight, described by its
  // kind, data and handshake cycle
  bit           m_active = 0;
  bit           m_is_key = 0;
  logic [127:0] m_data = '0;
  int           m_T = 0;
  int           m_len = 0;
  bit           m_last_key = 0;
  logic [31:0]  m_key_rsp = '0;
  logic [127:0] m_st_rsp = '0;
  bit           acc_key = 0, acc_st = 0;
  int           acc_key_cyc = 0, acc_st_cyc = 0;
  bit           gnt_log[$];

  always @(negedge clk) begin : mdl
    logic ekr, esr, ekv, esv, eb;
    logic [31:0] es;
    int k;
    acc_key = 0;
    acc_st  = 0;
    if (cyc >= 1) begin
      ekr = 0; esr = 0; ekv = 0; esv = 0;
      eb = 0; es = '0;
      if (m_active) begin
        k = cyc - m_T;
        if (k <= m_len) begin
          eb = 1;
          es = m_data[(k-1)*32 +: 32];
        end else begin
          if (m_is_key) begin
            ekv = 1;
            m_key_rsp = subword(m_data[31:0]);
          end else begin
            esv = 1;
            m_st_rsp = subblock(m_data);
          end
          m_active = 0;
        end
      end
      if (!m_active && rst_n) begin
        if (key_v &&
            (!st_v || KP0 != 0 || !m_last_key))
          ekr = 1;
        else if (st_v)
          esr = 1;
      end
      chk("key_ready", key_rdy, ekr);
      chk("st_ready", st_rdy, esr);
      chk("busy", busy, eb);
      chk("sbox_in", sin, es);
      chk("key_rsp_valid", key_rv, ekv);
      chk("st_rsp_valid", st_rv, esv);
      chk("key_rsp_word", key_rw, m_key_rsp);
      chk("st_rsp_data", st_rd, m_st_rsp);
      if (ekr) begin
        acc_key = 1;
        acc_key_cyc = cyc;
        gnt_log.push_back(1'b1);
        m_active = 1; m_is_key = 1;
        m_data = {96'b0, key_w};
        m_T = cyc; m_len = 1; m_last_key = 1;
      end else if (esr) begin
        acc_st = 1;
        acc_st_cyc = cyc;
        gnt_log.push_back(1'b0);
        m_active = 1; m_is_key = 0;
        m_data = st_d;
        m_T = cyc; m_len = 4; m_last_key = 0;
      end
      if (!rst_n) begin
        m_active = 0;
        m_last_key = 0;
        m_key_rsp = '0;
        m_st_rsp = '0;
      end
    end
  end

  bit keep_key = 0, keep_st = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (acc_key) begin
      if (keep_key) key_w = $urandom;
      else key_v = 0;
    end
    if (acc_st) begin
      if (keep_st)
        st_d = {$urandom, $urandom,
                $urandom, $urandom};
      else st_v = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wait_acc(input bit is_key,
                          output int t);
    bit got;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (is_key ? acc_key : acc_st) got = 1;
    end
    t = is_key ? acc_key_cyc : acc_st_cyc;
    chk(is_key ? "key_accept" : "st_accept",
        got, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int t, sT, kT, n_acc, n_srdy;

  initial begin
    rst_n = 0; key_v = 0; st_v = 0;
    key_w = '0; st_d = '0;
    rst1_n = 0; k1_v = 0; s1_v = 0;
    k1_w = 32'h01000053; s1_d = '0;
    idle(2);
    rst_n = 1;
    step();

    key_w = 32'h01000053;
    key_v = 1;
    wait_acc(1, t);
    chk("key_busy_t1", busy, 1);
    step();
    chk("key_rsp_t2", key_rv, 1);
    chk("key_rsp_lit", key_rw, 32'h7c6363ed);
    chk("key_idle_t2", busy, 0);
    step();
    chk("key_pulse_end", key_rv, 0);

    st_d = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    st_v = 1;
    wait_acc(0, t);
    chk("st_w0", sin, 32'h03020100);
    idle(3);
    chk("st_w3", sin, 32'h0f0e0d0c);
    step();
    chk("st_rsp_t5", st_rv, 1);
    chk("st_rsp_lit", st_rd,
        128'h76abd7fe_2b670130_c56f6bf2_7b777c63);
    chk("key_rsp_hold", key_rw, 32'h7c6363ed);
    idle(2);

    gnt_log.delete();
    keep_key = 1; keep_st = 1;
    key_w = $urandom;
    st_d = {$urandom, $urandom, $urandom, $urandom};
    key_v = 1; st_v = 1;
    for (int i = 0; i < 40 && gnt_log.size() < 4; i++)
      step();
    chk("tie_count", gnt_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("tie_order%0d", i),
          (i < gnt_log.size()) ? gnt_log[i] : 1'bx,
          (i % 2) == 0);
    keep_key = 0; keep_st = 0;
    key_v = 0; st_v = 0;
    idle(8);

    st_d = {$urandom, $urandom, $urandom, $urandom};
    st_v = 1;
    wait_acc(0, sT);
    step();
    key_w = $urandom;
    key_v = 1;
    wait_acc(1, kT);
    chk("key_wait_cycles", kT - sT, 5);
    step();
    chk("key_rsp_after_burst", key_rv, 1);
    idle(3);

    st_d = {$urandom, $urandom, $urandom, $urandom};
    st_v = 1;
    wait_acc(0, t);
    idle(2);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("rst_busy", busy, 0);
    chk("rst_sbox_in", sin, 0);
    chk("rst_st_rsp", st_rd, 0);
    chk("rst_key_rsp", key_rw, 0);
    idle(6);
    gnt_log.delete();
    key_w = $urandom;
    st_d = {$urandom, $urandom, $urandom, $urandom};
    key_v = 1; st_v = 1;
    for (int i = 0; i < 20 && gnt_log.size() < 1; i++)
      step();
    chk("rst_tie_first_key",
        (gnt_log.size() > 0) ? gnt_log[0] : 1'bx, 1);
    idle(10);
    key_v = 0; st_v = 0;
    idle(6);

    for (int i = 0; i < 600; i++) begin
      step();
      if (!key_v && $urandom_range(3) == 0) begin
        key_v = 1;
        key_w = $urandom;
      end
      if (!st_v && $urandom_range(4) == 0) begin
        st_v = 1;
        st_d = {$urandom, $urandom,
                $urandom, $urandom};
      end
      if ($urandom_range(150) == 0) begin
        rst_n = 0; key_v = 0; st_v = 0;
      end else begin
        rst_n = 1;
      end
    end
    key_v = 0; st_v = 0; rst_n = 1;
    idle(8);

    k1_w = 32'h01000053;
    s1_d = {$urandom, $urandom, $urandom, $urandom};
    rst1_n = 1; k1_v = 1; s1_v = 1;
    #1;
    n_acc = 0;
    n_srdy = 0;
    for (int i = 0; i < 20; i++) begin
      if (k1_rdy && k1_v) n_acc++;
      if (s1_rdy) n_srdy++;
      step();
    end
    chk("prio_key_accepts", n_acc, 10);
    chk("prio_st_ready", n_srdy, 0);
    chk("prio_key_rsp", k1_rw, subword(k1_w));
    k1_v = 0; s1_v = 0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule
